// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES pad reader.
// Contents: reader FSM state encoding and serial button index constants
// (bit i of a buttons word is serial bit i).
// Optional feature macro used by the reader: CTRL_DEBOUNCE_EN.
package snes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Serial bit positions of each button; 12-15 are reserved by the pad.
    localparam int unsigned BTN_B      = 0;
    localparam int unsigned BTN_Y      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;
    localparam int unsigned BTN_A      = 8;
    localparam int unsigned BTN_X      = 9;
    localparam int unsigned BTN_L      = 10;
    localparam int unsigned BTN_R      = 11;

endpackage

// File: rtl/snes_pad_shift.sv
// Per-pad receive path: 2-flop synchroniser on the serial data line, an
// indexed NUM_BITS capture register and the published buttons word.
// Optional: CTRL_DEBOUNCE_EN -- publish a frame only when it matches the
// previous raw frame.
// Ports:
//   clock, reset_n  system clock, async active-low reset
//   i_data          raw serial data from the pad (active-low, idle high)
//   i_sample        capture synced data into bit i_idx this cycle
//   i_idx           bit index being captured
//   i_load          end of frame: update the published word
//   o_buttons       active-high buttons word
module snes_pad_shift
    import snes_pad_pkg::*;
#(
    parameter int unsigned NUM_BITS = 16,
    parameter int unsigned IDX_W    = $clog2(NUM_BITS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                i_data,
    input  logic                i_sample,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic                i_load,
    output logic [NUM_BITS-1:0] o_buttons
);

    logic                r_sync1;
    logic                r_sync2;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] r_buttons;

    // Synchroniser resets to the idle (released) level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_data;
            r_sync2 <= r_sync1;
        end
    end

    // Raw capture, still active-low; every bit is rewritten each frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '1;
        end else if (i_sample) begin
            r_shift[i_idx] <= r_sync2;
        end
    end

`ifdef CTRL_DEBOUNCE_EN
    logic [NUM_BITS-1:0] r_prev;

    // Publish only frames seen twice in a row; history updates every frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= '1;
            r_buttons <= '0;
        end else if (i_load) begin
            r_prev <= r_shift;
            if (r_shift == r_prev) begin
                r_buttons <= ~r_shift;
            end
        end
    end
`else
    // Publish every frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_buttons <= '0;
        end else if (i_load) begin
            r_buttons <= ~r_shift;
        end
    end
`endif

    assign o_buttons = r_buttons;

endmodule

// File: rtl/snes_pad_reader.sv
// Host-side reader for two SNES-style serial pads. Polls autonomously once
// per POLL_CYCLES: latch pulse, NUM_BITS shift-clock pulses, then publishes
// active-high button words with a one-cycle valid pulse.
// Optional: CTRL_DEBOUNCE_EN (see snes_pad_shift) gates button updates.
// Ports:
//   clock, reset_n          system clock, async active-low reset
//   pad_data[1:0]           serial data, [0]=P1 [1]=P2, active-low
//   pad_latch               latch strobe to both pads, active-high
//   pad_clk                 shift clock to both pads, idles high
//   buttons_p1/buttons_p2   active-high buttons, bit i = serial bit i
//   valid                   one-cycle pulse at frame completion
//   busy                    high from latch rise until valid
module snes_pad_reader
    import snes_pad_pkg::*;
#(
    parameter int unsigned HALF_BIT_CYCLES = 300,
    parameter int unsigned POLL_CYCLES     = 833333,
    parameter int unsigned NUM_BITS        = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [1:0]          pad_data,
    output logic                pad_latch,
    output logic                pad_clk,
    output logic [NUM_BITS-1:0] buttons_p1,
    output logic [NUM_BITS-1:0] buttons_p2,
    output logic                valid,
    output logic                busy
);

    localparam int unsigned POLL_W  = $clog2(POLL_CYCLES);
    localparam int unsigned PHASE_W = $clog2(2 * HALF_BIT_CYCLES);
    localparam int unsigned IDX_W   = $clog2(NUM_BITS);

    state_t               r_state;
    state_t               w_next_state;
    logic [POLL_W-1:0]    r_poll;
    logic [PHASE_W-1:0]   r_phase;
    logic [PHASE_W-1:0]   w_next_phase;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_next_idx;
    logic                 w_sample;
    logic                 w_load;
    logic                 r_latch;
    logic                 r_pclk;
    logic                 r_valid;
    logic                 r_busy;

    // Free-running frame-rate counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_poll <= '0;
        end else if (r_poll == POLL_W'(POLL_CYCLES - 1)) begin
            r_poll <= '0;
        end else begin
            r_poll <= r_poll + 1'b1;
        end
    end

    // State, timing counters and outputs; outputs are decoded from the
    // next state so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_idx   <= '0;
            r_latch <= 1'b0;
            r_pclk  <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_phase <= w_next_phase;
            r_idx   <= w_next_idx;
            r_latch <= (w_next_state == ST_LATCH);
            r_pclk  <= (w_next_state != ST_LOW);
            r_valid <= (w_next_state == ST_DONE);
            r_busy  <= (w_next_state == ST_LATCH) || (w_next_state == ST_LOW) ||
                       (w_next_state == ST_HIGH);
        end
    end

    // Next-state logic; poll wraps are only looked at from IDLE.
    always_comb begin
        w_next_state = r_state;
        w_next_phase = r_phase + 1'b1;
        w_next_idx   = r_idx;
        w_sample     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_phase = '0;
                if (r_poll == '0) begin
                    w_next_state = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (r_phase == PHASE_W'(2 * HALF_BIT_CYCLES - 1)) begin
                    w_next_state = ST_LOW;
                    w_next_phase = '0;
                end
            end
            ST_LOW: begin
                if (r_phase == PHASE_W'(HALF_BIT_CYCLES - 1)) begin
                    w_sample     = 1'b1;
                    w_next_state = ST_HIGH;
                    w_next_phase = '0;
                end
            end
            ST_HIGH: begin
                if (r_phase == PHASE_W'(HALF_BIT_CYCLES - 1)) begin
                    w_next_phase = '0;
                    if (r_idx == IDX_W'(NUM_BITS - 1)) begin
                        w_next_state = ST_DONE;
                        w_next_idx   = '0;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_LOW;
                        w_next_idx   = r_idx + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
                w_next_phase = '0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_phase = '0;
                w_next_idx   = '0;
            end
        endcase
    end

    snes_pad_shift #(
        .NUM_BITS (NUM_BITS),
        .IDX_W    (IDX_W)
    ) u_pad1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_data    (pad_data[0]),
        .i_sample  (w_sample),
        .i_idx     (r_idx),
        .i_load    (w_load),
        .o_buttons (buttons_p1)
    );

    snes_pad_shift #(
        .NUM_BITS (NUM_BITS),
        .IDX_W    (IDX_W)
    ) u_pad2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_data    (pad_data[1]),
        .i_sample  (w_sample),
        .i_idx     (r_idx),
        .i_load    (w_load),
        .o_buttons (buttons_p2)
    );

    assign pad_latch = r_latch;
    assign pad_clk   = r_pclk;
    assign valid     = r_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Self-checking bench for snes_pad_reader with a behavioural pad model on
// each data line. Honours CTRL_DEBOUNCE_EN when defined.
module tb_snes_pad_reader;
    import snes_pad_pkg::*;

    localparam int unsigned HB        = 4;
    localparam int unsigned POLL      = 200;
    localparam int unsigned NB        = 16;
    localparam int unsigned FRAME_LEN = 34 * HB;
    localparam int unsigned LATCH_LEN = 2 * HB;
`ifdef CTRL_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  pad_data;
    logic        pad_latch;
    logic        pad_clk;
    logic [15:0] buttons_p1;
    logic [15:0] buttons_p2;
    logic        valid;
    logic        busy;

    logic [15:0] p1_word = 16'h0000;
    logic [15:0] p2_word = 16'h0000;
    int          pad_cnt = 0;
    int unsigned cyc     = 0;
    int unsigned last_rise = 0;
    bit          have_rise = 1'b0;
    int          checks  = 0;
    int          errors  = 0;

    logic [15:0] m_prev1, m_prev2, m_btn1, m_btn2;

    snes_pad_reader #(
        .HALF_BIT_CYCLES (HB),
        .POLL_CYCLES     (POLL),
        .NUM_BITS        (NB)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .buttons_p1 (buttons_p1),
        .buttons_p2 (buttons_p2),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Pad model: latch reloads bit 0, each rising pad_clk presents the next bit.
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) pad_cnt <= 0;
        else if (pad_cnt < 16) pad_cnt <= pad_cnt + 1;
    end

    function automatic logic pad_bit(input logic [15:0] w, input int c);
        if (c >= 0 && c < 16) return ~w[c[3:0]];
        return 1'b1;
    endfunction

    assign pad_data[0] = pad_bit(p1_word, pad_cnt);
    assign pad_data[1] = pad_bit(p2_word, pad_cnt);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: buttons follow the pressed set, or with debounce only a set
    // seen in two consecutive frames.
    function automatic void model_reset();
        m_prev1 = 16'h0; m_prev2 = 16'h0; m_btn1 = 16'h0; m_btn2 = 16'h0;
    endfunction

    function automatic void model_frame(input logic [15:0] r1, input logic [15:0] r2);
        if (!DEB || r1 == m_prev1) m_btn1 = r1;
        if (!DEB || r2 == m_prev2) m_btn2 = r2;
        m_prev1 = r1;
        m_prev2 = r2;
    endfunction

    // Observe one frame from latch rise through one cycle past valid.
    task automatic do_frame(input logic [15:0] e1, input logic [15:0] e2, input string tag);
        int n, k, latch_hi, falls, cur_low, bad_low, busy_drop, btn_moves;
        logic prev_clk;
        logic [15:0] b1_0, b2_0;
        n = 0;
        while (pad_latch !== 1'b1 && n < int'(2 * POLL)) begin
            @(negedge clock); n++;
        end
        check({tag, "_latch_seen"}, 32'(pad_latch), 32'd1);
        if (pad_latch !== 1'b1) return;
        if (have_rise) check({tag, "_period"}, 32'(cyc - last_rise), 32'(POLL));
        last_rise = cyc; have_rise = 1'b1;
        b1_0 = buttons_p1; b2_0 = buttons_p2;
        k = 0; latch_hi = 0; falls = 0; cur_low = 0; bad_low = 0;
        busy_drop = 0; btn_moves = 0; prev_clk = 1'b1;
        while (k < int'(2 * FRAME_LEN)) begin
            if (pad_latch) latch_hi++;
            if (prev_clk && !pad_clk) begin falls++; cur_low = 0; end
            if (!pad_clk) cur_low++;
            if (!prev_clk && pad_clk && cur_low != int'(HB)) bad_low++;
            prev_clk = pad_clk;
            if (valid) break;
            if (!busy) busy_drop++;
            if (buttons_p1 !== b1_0 || buttons_p2 !== b2_0) btn_moves++;
            @(negedge clock); k++;
        end
        check({tag, "_valid_seen"}, 32'(valid), 32'd1);
        check({tag, "_valid_offset"}, 32'(k), 32'(FRAME_LEN));
        check({tag, "_latch_len"}, 32'(latch_hi), 32'(LATCH_LEN));
        check({tag, "_clk_falls"}, 32'(falls), 32'(NB));
        check({tag, "_bad_low_len"}, 32'(bad_low), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy_drop), 32'd0);
        check({tag, "_early_btn_change"}, 32'(btn_moves), 32'd0);
        check({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
        check({tag, "_p1"}, 32'(buttons_p1), 32'(e1));
        check({tag, "_p2"}, 32'(buttons_p2), 32'(e2));
        @(negedge clock);
        check({tag, "_valid_pulse"}, 32'(valid), 32'd0);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_p1_hold"}, 32'(buttons_p1), 32'(e1));
    endtask

    typedef struct packed {
        logic [15:0] p1, p2, e1_nd, e2_nd, e1_db, e2_db;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] w_p1, w_p2, r1, r2;
        logic [15:0] seq_raw [3];
        logic [15:0] seq_exp [3];
        int falls, n, vseen;
        logic prev;

        w_p1 = 16'((1 << BTN_B) | (1 << BTN_START));
        w_p2 = 16'((1 << BTN_A) | (1 << BTN_R));
        vecs[0] = '{p1: w_p1,     p2: 16'h0000, e1_nd: w_p1,     e2_nd: 16'h0000, e1_db: 16'h0000, e2_db: 16'h0000};
        vecs[1] = '{p1: w_p1,     p2: 16'h0000, e1_nd: w_p1,     e2_nd: 16'h0000, e1_db: w_p1,     e2_db: 16'h0000};
        vecs[2] = '{p1: 16'h0000, p2: w_p2,     e1_nd: 16'h0000, e2_nd: w_p2,     e1_db: w_p1,     e2_db: 16'h0000};
        vecs[3] = '{p1: 16'h0000, p2: w_p2,     e1_nd: 16'h0000, e2_nd: w_p2,     e1_db: 16'h0000, e2_db: w_p2};
        vecs[4] = '{p1: 16'hFFFF, p2: 16'hFFFF, e1_nd: 16'hFFFF, e2_nd: 16'hFFFF, e1_db: 16'h0000, e2_db: w_p2};
        vecs[5] = '{p1: 16'hFFFF, p2: 16'hFFFF, e1_nd: 16'hFFFF, e2_nd: 16'hFFFF, e1_db: 16'hFFFF, e2_db: 16'hFFFF};
        vecs[6] = '{p1: 16'h0000, p2: 16'h0000, e1_nd: 16'h0000, e2_nd: 16'h0000, e1_db: 16'hFFFF, e2_db: 16'hFFFF};
        vecs[7] = '{p1: 16'h0081, p2: 16'h0410, e1_nd: 16'h0081, e2_nd: 16'h0410, e1_db: 16'hFFFF, e2_db: 16'hFFFF};
        vecs[8] = '{p1: 16'h0081, p2: 16'h0410, e1_nd: 16'h0081, e2_nd: 16'h0410, e1_db: 16'h0081, e2_db: 16'h0410};

        // Reset values while held.
        model_reset();
        p1_word = vecs[0].p1; p2_word = vecs[0].p2;
        repeat (3) @(negedge clock);
        check("rst_latch", 32'(pad_latch), 32'd0);
        check("rst_clk", 32'(pad_clk), 32'd1);
        check("rst_p1", 32'(buttons_p1), 32'h0);
        check("rst_p2", 32'(buttons_p2), 32'h0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        reset_n = 1'b1;
        @(negedge clock);
        check("first_latch", 32'(pad_latch), 32'd1);

        // Table-driven frames, back to back.
        for (int i = 0; i < 9; i++) begin
            p1_word = vecs[i].p1; p2_word = vecs[i].p2;
            model_frame(vecs[i].p1, vecs[i].p2);
            do_frame(DEB ? vecs[i].e1_db : vecs[i].e1_nd,
                     DEB ? vecs[i].e2_db : vecs[i].e2_nd, $sformatf("vec%0d", i));
        end

        // Abort a frame with reset during bit 7.
        p1_word = 16'h1234; p2_word = 16'h8001;
        n = 0;
        while (pad_latch !== 1'b1 && n < int'(2 * POLL)) begin @(negedge clock); n++; end
        check("abort_latch_seen", 32'(pad_latch), 32'd1);
        falls = 0; prev = 1'b1; n = 0;
        while (falls < 8 && n < 200) begin
            @(negedge clock); n++;
            if (prev && !pad_clk) falls++;
            prev = pad_clk;
        end
        check("abort_at_bit7", 32'(falls), 32'd8);
        #2 reset_n = 1'b0;
        #1;
        check("abort_latch", 32'(pad_latch), 32'd0);
        check("abort_clk", 32'(pad_clk), 32'd1);
        check("abort_p1", 32'(buttons_p1), 32'h0);
        check("abort_p2", 32'(buttons_p2), 32'h0);
        check("abort_valid", 32'(valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        vseen = 0;
        repeat (5) begin @(negedge clock); if (valid) vseen++; end
        check("abort_no_valid", 32'(vseen), 32'd0);

        model_reset();
        have_rise = 1'b0;
        seq_raw[0] = 16'h0001; seq_raw[1] = 16'h0002; seq_raw[2] = 16'h0002;
        seq_exp[0] = DEB ? 16'h0000 : 16'h0001;
        seq_exp[1] = DEB ? 16'h0000 : 16'h0002;
        seq_exp[2] = 16'h0002;
        p1_word = seq_raw[0]; p2_word = 16'h0000;
        reset_n = 1'b1;
        @(negedge clock);
        check("restart_latch", 32'(pad_latch), 32'd1);
        for (int i = 0; i < 3; i++) begin
            p1_word = seq_raw[i];
            model_frame(seq_raw[i], 16'h0000);
            do_frame(seq_exp[i], 16'h0000, $sformatf("deb%0d", i));
        end

        // Random frames against the reference model; repeats exercise debounce.
        r1 = 16'h0002; r2 = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                r1 = 16'($urandom);
                r2 = 16'($urandom);
            end
            p1_word = r1; p2_word = r2;
            model_frame(r1, r2);
            do_frame(m_btn1, m_btn2, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
